// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-facing bundle of the branch resolve queue: enqueue,
// resolve, recovery and predictor-training signals.
interface branch_resolve_queue_if #(
  parameter int PC_W   = 16,
  parameter int HIST_W = 4,
  parameter int PCI_W  = 3
) ();
  logic                      enq_valid;
  logic [PC_W-1:0]           enq_pc;
  logic                      enq_pred_taken;
  logic [HIST_W-1:0]         enq_hist;
  logic                      enq_ready;
  logic                      res_valid;
  logic                      res_taken;
  logic [PC_W-1:0]           res_target;
  logic                      mispredict;
  logic [PC_W-1:0]           recover_pc;
  logic                      upd_valid;
  logic [PCI_W+HIST_W-1:0]   upd_pht_ind;
  logic [PCI_W-1:0]          upd_bht_ind;
  logic                      upd_taken;
  logic [HIST_W-1:0]         upd_hist;
  logic                      q_empty;

  modport master (
    output enq_valid, enq_pc, enq_pred_taken, enq_hist,
    output res_valid, res_taken, res_target,
    input  enq_ready, q_empty, mispredict, recover_pc,
    input  upd_valid, upd_pht_ind, upd_bht_ind, upd_taken, upd_hist
  );

  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, enq_hist,
    input  res_valid, res_taken, res_target,
    output enq_ready, q_empty, mispredict, recover_pc,
    output upd_valid, upd_pht_ind, upd_bht_ind, upd_taken, upd_hist
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; resolves oldest-first, flags mispredicts
// and trains the predictor. BRQ_PERF_STATS_EN adds resolve/mispredict counters.
module branch_resolve_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 16,
  parameter int HIST_W = 4,
  parameter int PCI_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef BRQ_PERF_STATS_EN
  output logic [15:0] stat_resolved,
  output logic [15:0] stat_mispred,
`endif
  branch_resolve_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic              pred_mem [DEPTH];
  logic [HIST_W-1:0] hist_mem [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [PTR_W:0]   count;

  logic full, do_enq, do_res, mis;
  logic [PC_W-1:0]   head_pc;
  logic [HIST_W-1:0] head_hist;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign bus.enq_ready = !full;
  assign bus.q_empty   = (count == '0);

  assign head_pc   = pc_mem[head];
  assign head_hist = hist_mem[head];

  // Full is judged before the edge, so a same-cycle resolve never frees a slot for enqueue
  assign do_enq = bus.enq_valid && !full;
  assign do_res = bus.res_valid && (count != '0);
  assign mis    = do_res && (bus.res_taken != pred_mem[head]);

  always_ff @(posedge clk) begin
    if (do_enq) begin
      pc_mem[tail]   <= bus.enq_pc;
      pred_mem[tail] <= bus.enq_pred_taken;
      hist_mem[tail] <= bus.enq_hist;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mis) begin
      // Everything younger than the mispredicted head, including a same-cycle enqueue, is squashed
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + 1'b1;
      if (do_res) head <= head + 1'b1;
      case ({do_enq, do_res})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mispredict  <= 1'b0;
      bus.recover_pc  <= '0;
      bus.upd_valid   <= 1'b0;
      bus.upd_pht_ind <= '0;
      bus.upd_bht_ind <= '0;
      bus.upd_taken   <= 1'b0;
      bus.upd_hist    <= '0;
    end else begin
      bus.mispredict <= mis;
      bus.upd_valid  <= do_res;
      if (mis)
        bus.recover_pc <= bus.res_taken ? bus.res_target : head_pc + PC_W'(2);
      if (do_res) begin
        bus.upd_pht_ind <= {head_pc[PCI_W:1], head_hist};
        bus.upd_bht_ind <= head_pc[PCI_W:1];
        bus.upd_taken   <= bus.res_taken;
        bus.upd_hist    <= {head_hist[HIST_W-2:0], bus.res_taken};
      end
    end
  end

`ifdef BRQ_PERF_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      if (do_res && stat_resolved != 16'hFFFF) stat_resolved <= stat_resolved + 16'd1;
      if (mis && stat_mispred != 16'hFFFF)     stat_mispred  <= stat_mispred + 16'd1;
    end
  end
`endif
endmodule
